// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, derivations and state type for the FFT butterfly sequencer
//
// Purpose : defaults for transform size and pipeline latencies, helpers that
//           derive butterflies-per-stage (B) and write-back latency (L), and
//           the sequencer state enum.
// Ports   : none (package).
package fft_pkg;

    localparam int LOG2N_DEF  = 4;
    localparam int RD_LAT_DEF = 1;
    localparam int BF_LAT_DEF = 2;

    // Address and twiddle-exponent widths for the default transform size.
    localparam int ADDR_W_DEF = LOG2N_DEF;
    localparam int TW_W_DEF   = LOG2N_DEF - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } fft_state_t;

    // B = N/2 butterflies per stage.
    function automatic int bf_per_stage(input int log2n);
        return 1 << (log2n - 1);
    endfunction

    // L = read latency + butterfly latency.
    function automatic int pipe_lat(input int rd_lat, input int bf_lat);
        return rd_lat + bf_lat;
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// rtl/fft_delay_line.sv - fixed-depth register chain with asynchronous clear
//
// Purpose : delays a WIDTH-bit word by exactly DEPTH clock cycles.
// Ports   : i_clk   clock
//           i_rst   asynchronous active-high reset, clears every stage
//           i_data  word entering the chain
//           o_data  word that entered DEPTH cycles ago
module fft_delay_line
    import fft_pkg::*;
#(
    parameter int DEPTH = pipe_lat(RD_LAT_DEF, BF_LAT_DEF),
    parameter int WIDTH = 2 * ADDR_W_DEF + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft16_bf_sched.sv
// rtl/fft16_bf_sched.sv - radix-2 DIT butterfly sequencer for an in-place FFT
//
// Purpose : walks LOG2N stages, issuing one butterfly per cycle (read pair
//           plus twiddle exponent), inserts L drain cycles between stages and
//           produces write-back addresses delayed by L cycles.
// Ports   : i_clk, i_rst (async, active-high), i_start (sampled in IDLE)
//           o_busy, o_done (1-cycle pulse), o_stage
//           o_rd_en, o_rd_addr0, o_rd_addr1, o_tw_idx   read side
//           o_wr_en, o_wr_addr0, o_wr_addr1              write-back side
module fft16_bf_sched
    import fft_pkg::*;
#(
    parameter int LOG2N  = LOG2N_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int BF_LAT = BF_LAT_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [$clog2(LOG2N)-1:0]   o_stage,
    output logic                       o_rd_en,
    output logic [LOG2N-1:0]           o_rd_addr0,
    output logic [LOG2N-1:0]           o_rd_addr1,
    output logic [LOG2N-2:0]           o_tw_idx,
    output logic                       o_wr_en,
    output logic [LOG2N-1:0]           o_wr_addr0,
    output logic [LOG2N-1:0]           o_wr_addr1
);

    localparam int B  = bf_per_stage(LOG2N);
    localparam int L  = pipe_lat(RD_LAT, BF_LAT);
    localparam int SW = $clog2(LOG2N);
    localparam int BW = LOG2N - 1;
    localparam int DW = (L > 1) ? $clog2(L) : 1;

    fft_state_t      r_state;
    logic [SW-1:0]   r_stage;
    logic [BW-1:0]   r_bf;
    logic [DW-1:0]   r_drain;

    logic [LOG2N-1:0] w_bf_ext;
    logic [LOG2N-1:0] w_span;
    logic [LOG2N-1:0] w_pos;
    logic [LOG2N-1:0] w_grp;
    logic [LOG2N-1:0] w_addr0;
    logic [LOG2N-1:0] w_addr1;
    logic [LOG2N-2:0] w_tw;

    // Butterfly bf of stage s pairs addr0 = grp*2*span + pos with addr0 + span.
    always_comb begin
        w_bf_ext = {1'b0, r_bf};
        w_span   = {{(LOG2N-1){1'b0}}, 1'b1} << r_stage;
        w_pos    = w_bf_ext & (w_span - 1'b1);
        w_grp    = w_bf_ext >> r_stage;
        // Two shifts so s+1 never overflows the SW-bit stage counter.
        w_addr0  = ((w_grp << r_stage) << 1) | w_pos;
        w_addr1  = w_addr0 | w_span;
        // pos < span <= N/2, so pos always fits the twiddle width.
        w_tw     = w_pos[LOG2N-2:0] << (LOG2N - 1 - int'(r_stage));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_stage    <= '0;
            r_bf       <= '0;
            r_drain    <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_stage    <= '0;
            o_rd_en    <= 1'b0;
            o_rd_addr0 <= '0;
            o_rd_addr1 <= '0;
            o_tw_idx   <= '0;
        end else begin
            o_rd_en <= 1'b0;
            o_done  <= 1'b0;
            o_busy  <= (r_state == S_ISSUE) || (r_state == S_DRAIN);
            o_stage <= r_stage;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_ISSUE;
                        r_stage <= '0;
                        r_bf    <= '0;
                    end
                end
                S_ISSUE: begin
                    o_rd_en    <= 1'b1;
                    o_rd_addr0 <= w_addr0;
                    o_rd_addr1 <= w_addr1;
                    o_tw_idx   <= w_tw;
                    if (r_bf == BW'(B - 1)) begin
                        r_state <= S_DRAIN;
                        r_drain <= '0;
                    end else begin
                        r_bf <= r_bf + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // L idle read cycles so the last write of this stage
                    // lands before the next stage's first read.
                    if (r_drain == DW'(L - 1)) begin
                        if (r_stage == SW'(LOG2N - 1)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ISSUE;
                            r_stage <= r_stage + 1'b1;
                            r_bf    <= '0;
                        end
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                S_DONE: begin
                    o_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic [2*LOG2N:0] w_wr_bus;

    fft_delay_line #(
        .DEPTH (L),
        .WIDTH (2 * LOG2N + 1)
    ) u_wb_delay (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data ({o_rd_en, o_rd_addr0, o_rd_addr1}),
        .o_data (w_wr_bus)
    );

    assign o_wr_en    = w_wr_bus[2*LOG2N];
    assign o_wr_addr0 = w_wr_bus[2*LOG2N-1:LOG2N];
    assign o_wr_addr1 = w_wr_bus[LOG2N-1:0];

endmodule

// File: tb/tb_fft16_bf_sched.sv
// tb/tb_fft16_bf_sched.sv - scoreboard bench for the FFT butterfly sequencer
module tb_fft16_bf_sched;

    localparam int N  = 16;
    localparam int B  = 8;
    localparam int L  = 3;
    localparam int TB = 4 * (B + L);
    localparam real PI = 3.14159265358979323846;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic       busy, done, rd_en, wr_en;
    logic [1:0] stage;
    logic [3:0] ra0, ra1, wa0, wa1;
    logic [2:0] tw;

    logic       rst2 = 1'b1, start2 = 1'b0;
    logic       busy2, done2, rd_en2, wr_en2;
    logic [1:0] stage2;
    logic [3:0] rb0, rb1, wb0, wb1;
    logic [2:0] tw2;

    always #5 clk = ~clk;

    fft16_bf_sched dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_busy(busy), .o_done(done), .o_stage(stage),
        .o_rd_en(rd_en), .o_rd_addr0(ra0), .o_rd_addr1(ra1), .o_tw_idx(tw),
        .o_wr_en(wr_en), .o_wr_addr0(wa0), .o_wr_addr1(wa1)
    );

    fft16_bf_sched #(.LOG2N(4), .RD_LAT(2), .BF_LAT(2)) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_start(start2),
        .o_busy(busy2), .o_done(done2), .o_stage(stage2),
        .o_rd_en(rd_en2), .o_rd_addr0(rb0), .o_rd_addr1(rb1), .o_tw_idx(tw2),
        .o_wr_en(wr_en2), .o_wr_addr0(wb0), .o_wr_addr1(wb1)
    );

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int model_free = 0;

    typedef struct { int a0; int a1; int k; int s; int c; } iss_t;
    iss_t rd_q[$], wr_q[$], cap_q[$];
    int   t0_q[$], done_cyc_q[$];
    real  re_ram[N], im_ram[N];
    real  gre_q[$], gim_q[$];
    real  bre_q[$], bim_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_r(input string name, input int idx, input real act, input real exp);
        n_tests++;
        if (act - exp > 1e-6 || exp - act > 1e-6) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %f expected %f", name, idx, act, exp);
        end
    endtask

    function automatic int bitrev4(input int v);
        int r = 0;
        for (int i = 0; i < 4; i++) if ((v >> i) & 1) r |= 1 << (3 - i);
        return r;
    endfunction

    function automatic int pack(input int a0, input int a1, input int k);
        return a0 * 256 + a1 * 16 + k;
    endfunction

    // Reference: accepted start at edge t -> full issue/write schedule and
    // the DFT of the data currently sitting bit-reversed in RAM.
    task automatic accept(input int t);
        iss_t e;
        int   idx;
        real  xr, xi, th;
        t0_q.push_back(t);
        model_free = t + TB + 2;
        for (int s = 0; s < 4; s++) begin
            int span = 1 << s;
            idx = 0;
            for (int j = 0; j < N; j += 2 * span) begin
                for (int p = 0; p < span; p++) begin
                    e = '{j + p, j + p + span, p * N / (2 * span), s, t + 1 + s * (B + L) + idx};
                    rd_q.push_back(e);
                    e.c = e.c + L;
                    wr_q.push_back(e);
                    idx++;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            xr = 0.0; xi = 0.0;
            for (int n = 0; n < N; n++) begin
                th = 2.0 * PI * n * k / N;
                xr += re_ram[bitrev4(n)] * $cos(th) + im_ram[bitrev4(n)] * $sin(th);
                xi += im_ram[bitrev4(n)] * $cos(th) - re_ram[bitrev4(n)] * $sin(th);
            end
            gre_q.push_back(xr);
            gim_q.push_back(xi);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst && start && cyc >= model_free) accept(cyc);
    end

    // Monitor for the default instance: busy/done windows, issue and
    // write-back scoreboards, and a datapath model that reads at issue time.
    always @(negedge clk) begin
        int   exp_busy, exp_done;
        iss_t e;
        real  ar, ai, br, bi, wr, wi, tr, ti;
        exp_busy = 0; exp_done = 0;
        foreach (t0_q[i]) begin
            if (cyc >= t0_q[i] + 1 && cyc <= t0_q[i] + TB) exp_busy = 1;
            if (cyc == t0_q[i] + TB + 1) exp_done = 1;
        end
        chk("busy", int'(busy), exp_busy);
        chk("done", int'(done), exp_done);
        if (rd_en) begin
            if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                e = rd_q.pop_front();
                chk("rd_cycle", cyc, e.c);
                chk("rd_pair", pack(int'(ra0), int'(ra1), int'(tw)), pack(e.a0, e.a1, e.k));
                chk("rd_stage", int'(stage), e.s);
                cap_q.push_back('{int'(ra0), int'(ra1), int'(tw), int'(stage), cyc});
            end
            ar = re_ram[ra0]; ai = im_ram[ra0];
            br = re_ram[ra1]; bi = im_ram[ra1];
            wr = $cos(2.0 * PI * tw / N); wi = -$sin(2.0 * PI * tw / N);
            tr = br * wr - bi * wi; ti = br * wi + bi * wr;
            bre_q.push_back(ar + tr); bim_q.push_back(ai + ti);
            bre_q.push_back(ar - tr); bim_q.push_back(ai - ti);
        end
        if (wr_en) begin
            if (wr_q.size() == 0 || bre_q.size() < 2) chk("wr_unexpected", 1, 0);
            else begin
                e = wr_q.pop_front();
                chk("wr_cycle", cyc, e.c);
                chk("wr_pair", pack(int'(wa0), int'(wa1), 0), pack(e.a0, e.a1, 0));
                re_ram[wa0] = bre_q.pop_front(); im_ram[wa0] = bim_q.pop_front();
                re_ram[wa1] = bre_q.pop_front(); im_ram[wa1] = bim_q.pop_front();
            end
        end
        if (done) begin
            done_cyc_q.push_back(cyc);
            if (gre_q.size() < N) chk("gold_missing", 1, 0);
            else for (int k = 0; k < N; k++) begin
                chk_r("bin_re", k, re_ram[k], gre_q.pop_front());
                chk_r("bin_im", k, im_ram[k], gim_q.pop_front());
            end
        end
        while (t0_q.size() > 0 && cyc > t0_q[0] + TB + 1) void'(t0_q.pop_front());
    end

    // Monitor for the RD_LAT=2 instance: no read of an address whose write
    // is still outstanding, and each write exactly 4 cycles after its read.
    logic [N-1:0] pend2 = '0;
    int rd2_c_q[$];
    int n_rd2 = 0, n_wr2 = 0, done2_cyc = -1;
    always @(negedge clk) begin
        if (rd_en2) begin
            chk("gap_hazard", int'(pend2[rb0] | pend2[rb1]), 0);
            pend2[rb0] = 1'b1; pend2[rb1] = 1'b1;
            rd2_c_q.push_back(cyc);
            n_rd2++;
        end
        if (wr_en2) begin
            if (rd2_c_q.size() == 0) chk("wr2_unexpected", 1, 0);
            else chk("wr2_delay", cyc - rd2_c_q.pop_front(), 4);
            pend2[wb0] = 1'b0; pend2[wb1] = 1'b0;
            n_wr2++;
        end
        if (done2) done2_cyc = cyc;
    end

    task automatic load_ram(input int mode);
        real xr, xi;
        for (int n = 0; n < N; n++) begin
            case (mode)
                0: begin xr = (n == 0) ? 1.0 : 0.0; xi = 0.0; end
                1: begin xr = $sin(2.0 * PI * 3 * n / N); xi = 0.0; end
                default: begin
                    xr = (real'($urandom_range(2000)) - 1000.0) / 1000.0;
                    xi = (real'($urandom_range(2000)) - 1000.0) / 1000.0;
                end
            endcase
            re_ram[bitrev4(n)] = xr;
            im_ram[bitrev4(n)] = xi;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_rd_left"}, rd_q.size(), 0);
        chk({tag, "_wr_left"}, wr_q.size(), 0);
        chk({tag, "_gold_left"}, gre_q.size(), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk(tag, int'({busy, done, stage, rd_en, ra0, ra1, tw, wr_en, wa0, wa1}), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_outputs");
        rst = 1'b0;
        @(negedge clk);

        // Impulse, plus fixed address/twiddle table checks.
        load_ram(0);
        cap_q.delete();
        pulse_start();
        repeat (TB + 4) @(negedge clk);
        check_drained("impulse");
        chk("cap_count", cap_q.size(), 32);
        if (cap_q.size() == 32) begin
            for (int i = 0; i < 8; i++)
                chk("tab_s0", pack(cap_q[i].a0, cap_q[i].a1, cap_q[i].k), pack(2 * i, 2 * i + 1, 0));
            chk("tab_s1_0", pack(cap_q[8].a0, cap_q[8].a1, cap_q[8].k), pack(0, 2, 0));
            chk("tab_s1_1", pack(cap_q[9].a0, cap_q[9].a1, cap_q[9].k), pack(1, 3, 4));
            chk("tab_s1_2", pack(cap_q[10].a0, cap_q[10].a1, cap_q[10].k), pack(4, 6, 0));
            chk("tab_s1_3", pack(cap_q[11].a0, cap_q[11].a1, cap_q[11].k), pack(5, 7, 4));
            chk("tab_s2_5", pack(cap_q[21].a0, cap_q[21].a1, cap_q[21].k), pack(9, 13, 2));
            chk("tab_s3_7", pack(cap_q[31].a0, cap_q[31].a1, cap_q[31].k), pack(7, 15, 7));
        end

        // Sine and random transforms.
        for (int m = 1; m <= 3; m++) begin
            load_ram(m);
            pulse_start();
            repeat (TB + 4) @(negedge clk);
            check_drained("xform");
        end

        // i_start held for 60 cycles: two transforms, 46 cycles apart.
        load_ram(2);
        done_cyc_q.delete();
        @(negedge clk); start = 1'b1;
        repeat (60) @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check_drained("held");
        chk("held_done_count", done_cyc_q.size(), 2);
        if (done_cyc_q.size() == 2) chk("held_done_gap", done_cyc_q[1] - done_cyc_q[0], 46);

        // Reset while stage 2 is issuing.
        load_ram(2);
        pulse_start();
        repeat (25) @(negedge clk);
        chk("pre_reset_stage", int'(stage), 2);
        @(posedge clk); #2;
        rst = 1'b1;
        rd_q.delete(); wr_q.delete(); t0_q.delete();
        gre_q.delete(); gim_q.delete(); bre_q.delete(); bim_q.delete();
        model_free = 0;
        #1;
        check_zero_outputs("midrun_reset_outputs");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        load_ram(2);
        pulse_start();
        repeat (TB + 4) @(negedge clk);
        check_drained("post_reset");

        // RD_LAT=2 instance: done at cycle 49 with a hazard-free drain gap.
        begin
            int t2;
            @(negedge clk); rst2 = 1'b0;
            @(negedge clk); start2 = 1'b1;
            t2 = cyc + 1;
            @(negedge clk); start2 = 1'b0;
            for (int i = 0; i < 80 && done2_cyc < 0; i++) @(negedge clk);
            chk("lat2_done_cycle", done2_cyc - t2, 49);
            chk("lat2_rd_count", n_rd2, 32);
            chk("lat2_wr_count", n_wr2, 32);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
